// File: rtl/mem_if_pkg.sv
// Shared memory-interface types and defaults.
// FSM states, access codes and default sizes for the burst master.
package mem_if_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WFETCH,
        ACCESS,
        RDOUT,
        DONE
    } state_t;

    localparam logic MEM_WR = 1'b1;
    localparam logic MEM_RD = 1'b0;

    localparam int MEM_WIDTH = 16;
    localparam int MEM_DEPTH = 64;

endpackage

// File: rtl/mem_addr_gen.sv
// Burst address/length tracker with modulo-DEPTH wrap.
// Length above DEPTH is clamped on load.
module mem_addr_gen
    import mem_if_pkg::*;
#(
    parameter int DEPTH      = MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [ADDR_WIDTH:0]   rem_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH:0]   LEN_MAX  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;

    // Load a new burst or advance by one word.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = addr_i;
            rem_d  = (len_i > LEN_MAX) ? LEN_MAX : len_i;
        end else if (step_i) begin
            addr_d = (addr_q == ADDR_TOP) ? '0 : addr_q + 1'b1;
            rem_d  = (rem_q == '0) ? '0 : rem_q - 1'b1;
        end
    end

    // Address and remaining-count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign rem_o  = rem_q;
    assign last_o = (rem_q == (ADDR_WIDTH+1)'(1));

endmodule

// File: rtl/mem_burst_master.sv
// Burst command to single-word valid/ready memory accesses.
// Optional watchdog: define MEM_BURST_MASTER_TIMEOUT_EN.
module mem_burst_master
    import mem_if_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ADDR_WIDTH:0]   cmd_len_i,
    input  logic                  wd_valid_i,
    output logic                  wd_ready_o,
    input  logic [WIDTH-1:0]      wd_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  wr_rd_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
    ,
    output logic                  err_o
`endif
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t             state_q, state_d;
    logic               wr_q, wr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               ag_load, ag_step, ag_last;
    logic [ADDR_WIDTH:0] ag_rem;
    logic               burst_last;

`ifdef MEM_BURST_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
`endif

    mem_addr_gen #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (ag_load),
        .addr_i (cmd_addr_i),
        .len_i  (cmd_len_i),
        .step_i (ag_step),
        .addr_o (addr_o),
        .rem_o  (ag_rem),
        .last_o (ag_last)
    );

    // An empty counter also ends the burst, so it can never run away.
    assign burst_last = ag_last | (ag_rem == '0);

    // Next-state and datapath capture.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ag_load = 1'b0;
        ag_step = 1'b0;
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
        wdog_d  = '0;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    ag_load = 1'b1;
                    wr_d    = cmd_wr_i;
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    if (cmd_len_i == '0)
                        state_d = DONE;
                    else if (cmd_wr_i == MEM_WR)
                        state_d = WFETCH;
                    else
                        state_d = ACCESS;
                end
            end
            WFETCH: begin
                if (wd_valid_i) begin
                    wdata_d = wd_data_i;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (ready_i) begin
                    if (wr_q == MEM_WR) begin
                        ag_step = 1'b1;
                        state_d = burst_last ? DONE : WFETCH;
                    end else begin
                        rdata_d = rdata_i;
                        state_d = RDOUT;
                    end
                end
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
                else if (wdog_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            RDOUT: begin
                if (rd_ready_i) begin
                    ag_step = 1'b1;
                    state_d = burst_last ? DONE : ACCESS;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wr_q    <= MEM_RD;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign wd_ready_o  = (state_q == WFETCH);
    assign valid_o     = (state_q == ACCESS);
    assign rd_valid_o  = (state_q == RDOUT);
    assign done_o      = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign wr_rd_o     = wr_q;
    assign wdata_o     = wdata_q;
    assign rd_data_o   = rdata_q;
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
    assign err_o       = err_q;
`endif

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master with a random-latency memory.
// Expectations are queued by stimulus and popped by the monitor.
module tb_mem_burst_master;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic             cmd_wr_i = 1'b0;
    logic [AW-1:0]    cmd_addr_i = '0;
    logic [AW:0]      cmd_len_i = '0;
    logic             wd_valid_i = 1'b0;
    logic             wd_ready_o;
    logic [WIDTH-1:0] wd_data_i = '0;
    logic             rd_valid_o;
    logic             rd_ready_i = 1'b0;
    logic [WIDTH-1:0] rd_data_o;
    logic             busy_o;
    logic             done_o;
    logic [AW-1:0]    addr_o;
    logic [WIDTH-1:0] wdata_o;
    logic             wr_rd_o;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [WIDTH-1:0] rdata_i = '0;
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
    logic             err_o;
`endif

    mem_burst_master #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_wr_i(cmd_wr_i), .cmd_addr_i(cmd_addr_i),
        .cmd_len_i(cmd_len_i),
        .wd_valid_i(wd_valid_i), .wd_ready_o(wd_ready_o),
        .wd_data_i(wd_data_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_data_o(rd_data_o),
        .busy_o(busy_o), .done_o(done_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .wr_rd_o(wr_rd_o),
        .valid_o(valid_o), .ready_i(ready_i), .rdata_i(rdata_i)
`ifdef MEM_BURST_MASTER_TIMEOUT_EN
        , .err_o(err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic             wr;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } acc_t;

    acc_t             exp_acc[$];
    logic [WIDTH-1:0] exp_rd[$];
    logic [WIDTH-1:0] wd_src[$];
    logic [WIDTH-1:0] mem[DEPTH];

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int rd_taken = 0;
    int valid_cyc = 0;
    int wait_cnt = 0;
    int bp_word = -1;
    int bp_left = 0;
    bit wd_took = 0;
    bit wd_gap = 0;
    bit mem_stuck = 0;

    logic             pv_valid = 0, pv_ready = 0;
    logic             pv_rdv = 0, pv_rdr = 0;
    logic [AW-1:0]    p_addr = '0;
    logic [WIDTH-1:0] p_wdata = '0, p_rd = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Memory model: ready after 0..3 cycles, or never when stuck.
    always @(posedge clk_i) begin
        #1;
        ready_i = 1'b0;
        if (valid_o && !mem_stuck) begin
            if (wait_cnt == 0) begin
                ready_i = 1'b1;
                rdata_i = mem[addr_o];
                if (wr_rd_o) mem[addr_o] = wdata_o;
                wait_cnt = $urandom_range(3, 0);
            end else begin
                wait_cnt--;
            end
        end
    end

    // Read-data sink with optional backpressure on one word.
    always @(posedge clk_i) begin
        #1;
        if (rd_valid_o && rd_taken == bp_word && bp_left > 0) begin
            rd_ready_i = 1'b0;
            bp_left--;
        end else begin
            rd_ready_i = 1'b1;
        end
    end

    // Write-data source with optional random gaps.
    always @(posedge clk_i) begin
        #1;
        if (wd_took) begin
            if (wd_src.size() > 0) void'(wd_src.pop_front());
            wd_took = 0;
        end
        if (wd_src.size() > 0 &&
            !(wd_gap && $urandom_range(2, 0) != 0)) begin
            wd_valid_i = 1'b1;
            wd_data_i  = wd_src[0];
        end else begin
            wd_valid_i = 1'b0;
        end
    end

    // Monitor: pops the scoreboard at every handshake.
    always @(negedge clk_i) begin
        acc_t a;
        logic [WIDTH-1:0] r;
        if (!rst_i) begin
            if (valid_o) valid_cyc++;
            if (valid_o && pv_valid && !pv_ready) begin
                check("addr_hold", addr_o, p_addr);
                check("wdata_hold", wdata_o, p_wdata);
            end
            if (rd_valid_o && pv_rdv && !pv_rdr)
                check("rd_hold", rd_data_o, p_rd);
            if (wd_ready_o && !wd_valid_i)
                check("no_req_wo_data", valid_o, 0);
            if (valid_o && ready_i) begin
                if (exp_acc.size() == 0) begin
                    miss("acc_unexpected", addr_o);
                end else begin
                    a = exp_acc.pop_front();
                    check("acc_wr", wr_rd_o, a.wr);
                    check("acc_addr", addr_o, a.addr);
                    if (a.wr) check("acc_wdata", wdata_o, a.data);
                end
            end
            if (rd_valid_o && rd_ready_i) begin
                if (exp_rd.size() == 0) begin
                    miss("rd_unexpected", rd_data_o);
                end else begin
                    r = exp_rd.pop_front();
                    check("rd_data", rd_data_o, r);
                end
                rd_taken++;
            end
            if (wd_valid_i && wd_ready_o) wd_took = 1;
            if (done_o) done_cnt++;
        end
        pv_valid = valid_o;
        pv_ready = ready_i;
        pv_rdv   = rd_valid_o;
        pv_rdr   = rd_ready_i;
        p_addr   = addr_o;
        p_wdata  = wdata_o;
        p_rd     = rd_data_o;
    end

    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                            input logic [AW:0] len);
        check("cmd_ready_idle", cmd_ready_o, 1);
        cmd_wr_i    = wr;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int start);
        for (int i = 0; i < 1000 && done_cnt == start; i++) tick();
        check({name, "_done"}, done_cnt - start, 1);
        check({name, "_busy"}, busy_o, 0);
        check({name, "_acc_left"}, exp_acc.size(), 0);
        check({name, "_rd_left"}, exp_rd.size(), 0);
        tick();
        tick();
        check({name, "_one_pulse"}, done_cnt - start, 1);
    endtask

    task automatic push_acc(input logic wr, input logic [AW-1:0] addr,
                            input int len, input logic [WIDTH-1:0] base);
        acc_t a;
        for (int i = 0; i < len; i++) begin
            a.wr   = wr;
            a.addr = AW'((int'(addr) + i) % DEPTH);
            a.data = base + WIDTH'(i);
            exp_acc.push_back(a);
            if (wr) wd_src.push_back(a.data);
            else exp_rd.push_back(a.data);
        end
    endtask

    task automatic burst(input string name, input logic wr,
                         input logic [AW-1:0] addr, input int len,
                         input logic [WIDTH-1:0] base);
        int start;
        start = done_cnt;
        push_acc(wr, addr, len, base);
        send_cmd(wr, addr, (AW+1)'(len));
        wait_done(name, start);
    endtask

    initial begin
        int start;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        repeat (3) tick();
        rst_i = 1'b0;
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_wd_ready", wd_ready_o, 0);
        check("rst_addr", addr_o, 0);
        tick();

        burst("wr15", 1'b1, 6'h15, 5, 16'h1234);
        check("mem19", mem[6'h19], 16'h1238);
        burst("rd15", 1'b0, 6'h15, 5, 16'h1234);

        bp_word = 1;
        bp_left = 10;
        rd_taken = 0;
        burst("rd15_bp", 1'b0, 6'h15, 5, 16'h1234);
        check("bp_used", bp_left, 0);
        bp_word = -1;

        burst("wr3e", 1'b1, 6'h3E, 4, 16'h00A0);
        check("mem01", mem[6'h01], 16'h00A3);
        burst("rd3e", 1'b0, 6'h3E, 4, 16'h00A0);

        start = done_cnt;
        send_cmd(1'b1, 6'h05, 7'd0);
        check("len0_done", done_o, 1);
        check("len0_valid", valid_o, 0);
        tick();
        check("len0_idle", cmd_ready_o, 1);
        check("len0_count", done_cnt - start, 1);

        wd_gap = 1;
        start = done_cnt;
        push_acc(1'b1, 6'h20, 3, 16'hBEE0);
        send_cmd(1'b1, 6'h20, 7'd3);
        cmd_valid_i = 1'b1;
        cmd_wr_i    = 1'b0;
        cmd_addr_i  = 6'h00;
        cmd_len_i   = 7'd1;
        for (int i = 0; i < 3; i++) begin
            check("busy_no_accept", cmd_ready_o, 0);
            tick();
        end
        cmd_valid_i = 1'b0;
        wait_done("wr20_gap", start);
        wd_gap = 0;

        start = done_cnt;
        push_acc(1'b1, 6'h00, 64, 16'h5000);
        send_cmd(1'b1, 6'h00, 7'd65);
        wait_done("clamp", start);
        check("clamp_mem3f", mem[6'h3F], 16'h503F);

        rd_taken = 0;
        start = done_cnt;
        push_acc(1'b0, 6'h15, 5, 16'h5015);
        send_cmd(1'b0, 6'h15, 7'd5);
        for (int i = 0; i < 200 && rd_taken < 2; i++) tick();
        check("mid_reached", rd_taken, 2);
        rst_i = 1'b1;
        tick();
        exp_acc.delete();
        exp_rd.delete();
        check("mid_cmd_ready", cmd_ready_o, 1);
        check("mid_busy", busy_o, 0);
        check("mid_valid", valid_o, 0);
        check("mid_rd_valid", rd_valid_o, 0);
        check("mid_done", done_o, 0);
        check("mid_addr", addr_o, 0);
        check("mid_rd_data", rd_data_o, 0);
        check("mid_wr_rd", wr_rd_o, 0);
        check("mid_wdata", wdata_o, 0);
        rst_i = 1'b0;
        repeat (4) tick();
        check("mid_no_done", done_cnt - start, 0);

`ifdef MEM_BURST_MASTER_TIMEOUT_EN
        mem_stuck = 1;
        valid_cyc = 0;
        start = done_cnt;
        send_cmd(1'b0, 6'h03, 7'd2);
        for (int i = 0; i < 100 && done_cnt == start; i++) tick();
        check("to_done", done_cnt - start, 1);
        check("to_err", err_o, 1);
        check("to_cycles", valid_cyc, 8);
        mem_stuck = 0;
        tick();
        send_cmd(1'b1, 6'h00, 7'd0);
        check("to_err_clr", err_o, 0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
